ir_frame_controller: RTL

//  Sequences the IR transcriber datapath (read_bits/latest_bit) into complete NEC frames.

---
 rtl/vcr_remote_pkg.sv | 36 +++
 rtl/ir_edge_sync.sv | 33 +++
 rtl/ir_frame_controller.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/vcr_remote_pkg.sv
// Shared types and constants for the VCR remote (NEC IR) receive path.
//   state_e      : frame controller FSM states
//   nec_frame_t  : 32-bit NEC frame as received LSB-first {cmd_n, cmd, addr_n, addr}
//   nec_inverse_ok() : true when both bytes match their inverted copies
package vcr_remote_pkg;

  localparam int unsigned NEC_FRAME_BITS = 32;

  // Bit positions of each byte field inside the assembled frame word.
  localparam int unsigned ADDR_LSB   = 0;
  localparam int unsigned ADDR_N_LSB = 8;
  localparam int unsigned CMD_LSB    = 16;
  localparam int unsigned CMD_N_LSB  = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECEIVE,
    ST_CHECK,
    ST_DELIVER,
    ST_ERROR,
    ST_WAIT_IDLE
  } state_e;

  typedef struct packed {
    logic [7:0] cmd_n;
    logic [7:0] cmd;
    logic [7:0] addr_n;
    logic [7:0] addr;
  } nec_frame_t;

  function automatic logic nec_inverse_ok(input logic [NEC_FRAME_BITS-1:0] frame);
    return (frame[CMD_LSB +: 8]  == ~frame[CMD_N_LSB +: 8]) &&
           (frame[ADDR_LSB +: 8] == ~frame[ADDR_N_LSB +: 8]);
  endfunction

endpackage

// File: rtl/ir_edge_sync.sv
// Synchroniser for an asynchronous line plus a one-cycle rising-edge pulse.
// Parameters:
//   SYNC_STAGES : number of synchroniser flops (>= 2)
// Ports:
//   i_clk    : clock
//   i_reset  : synchronous active-high reset
//   i_sig    : asynchronous input line
//   o_rise   : one-cycle pulse when the synchronised line goes 0 -> 1
module ir_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_dly_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], i_sig};
      sync_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_rise = sync_q[SYNC_STAGES-1] & ~sync_dly_q;

endmodule

// File: rtl/ir_frame_controller.sv
// NEC frame controller: samples one bit per synchronised IR rising edge while the
// transcriber read window is open, assembles 32 bits LSB-first, validates the
// inverted-byte checks and presents addr/cmd through a valid/ready handshake.
// Parameters:
//   SYNC_STAGES    : IR line synchroniser depth (>= 2)
//   TIMEOUT_CYCLES : max cycles between bit edges while receiving
//   TIMEOUT_BITS   : width of the timeout counter
//   DEVICE_ADDR    : accepted address when ADDR_FILTER_EN is defined
// Ports:
//   i_clk, i_reset (sync, active-high), i_ir_signal (async raw line),
//   i_read_bits (transcriber read window), i_latest_bit (transcriber bit decision),
//   i_ready (consumer accept), o_valid/o_addr/o_cmd (frame output),
//   o_frame_error (1-cycle pulse), o_overrun (1-cycle pulse)
// Build option:
//   ADDR_FILTER_EN : frames for other addresses are dropped silently in CHECK.
module ir_frame_controller
  import vcr_remote_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 30000,
  parameter int unsigned TIMEOUT_BITS   = 15,
  parameter logic [7:0]  DEVICE_ADDR    = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ir_signal,
  input  logic       i_read_bits,
  input  logic       i_latest_bit,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_addr,
  output logic [7:0] o_cmd,
  output logic       o_frame_error,
  output logic       o_overrun
);

  state_e                    state_q, state_d;
  logic [NEC_FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [5:0]                cnt_q, cnt_d;
  logic [TIMEOUT_BITS-1:0]   tmo_q, tmo_d;
  logic                      bit_q;
  logic                      valid_q, valid_d;
  logic [7:0]                addr_q, addr_d;
  logic [7:0]                cmd_q, cmd_d;
  logic                      ir_rise;
  logic                      deliver;
  logic                      frame_error;
  logic                      overrun;
  nec_frame_t                frame;

  assign frame = nec_frame_t'(shreg_q);

  ir_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sig   (i_ir_signal),
    .o_rise  (ir_rise)
  );

`ifndef ADDR_FILTER_EN
  logic unused_device_addr;
  assign unused_device_addr = ^DEVICE_ADDR;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      // Transcriber clears its decision on the edge itself; keep last cycle's value.
      bit_q   <= i_latest_bit;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    deliver     = 1'b0;
    frame_error = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_read_bits) begin
          state_d = ST_RECEIVE;
          shreg_d = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end
      ST_RECEIVE: begin
        if (ir_rise) begin
          shreg_d = {bit_q, shreg_q[NEC_FRAME_BITS-1:1]};
          cnt_d   = cnt_q + 6'd1;
          tmo_d   = '0;
          if (cnt_q == 6'(NEC_FRAME_BITS - 1)) begin
            state_d = ST_CHECK;
          end else if (!i_read_bits) begin
            state_d = ST_ERROR;
          end
        end else begin
          if (tmo_q != '1) begin
            tmo_d = tmo_q + 1'b1;
          end
          if ((tmo_q == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1)) || !i_read_bits) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_CHECK: begin
        if (!nec_inverse_ok(shreg_q)) begin
          state_d = ST_ERROR;
`ifdef ADDR_FILTER_EN
        end else if (frame.addr != DEVICE_ADDR) begin
          state_d = ST_WAIT_IDLE;
`endif
        end else begin
          state_d = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        deliver = 1'b1;
        state_d = ST_WAIT_IDLE;
      end
      ST_ERROR: begin
        frame_error = 1'b1;
        state_d     = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (!i_read_bits) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output handshake runs independently of the FSM; an acceptance in the
  // same cycle as a delivery frees the slot for the new frame.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    overrun = 1'b0;
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
    if (deliver) begin
      if (!valid_q || i_ready) begin
        valid_d = 1'b1;
        addr_d  = frame.addr;
        cmd_d   = frame.cmd;
      end else begin
        overrun = 1'b1;
      end
    end
  end

  assign o_valid       = valid_q;
  assign o_addr        = addr_q;
  assign o_cmd         = cmd_q;
  assign o_frame_error = frame_error;
  assign o_overrun     = overrun;

endmodule
